// File: rtl/spi_flash_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the SPI NOR flash responder.
package spi_flash_pkg;

    localparam logic [7:0] FLASH_OP_READ      = 8'h03;
    localparam logic [7:0] FLASH_OP_FAST_READ = 8'h0B;
    localparam int         FLASH_ADDR_BITS    = 24;
    localparam int         FLASH_DUMMY_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } flash_state_e;

    // Flash byte lane 0 is the least significant byte of the backing word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] sel;
        case (lane)
            2'd0:    sel = word[7:0];
            2'd1:    sel = word[15:8];
            2'd2:    sel = word[23:16];
            2'd3:    sel = word[31:24];
            default: sel = 8'hFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchroniser for the SPI pins plus edge detection from stage 2 vs stage 3.
module spi_pin_sync (
    input  logic i_clock,
    input  logic i_sck,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ss_active,
    output logic o_ss_fall,
    output logic o_mosi_s
);

    logic [2:0] r_sck_sync;
    logic [2:0] r_ss_sync;
    logic [1:0] r_mosi_sync;

    // Pin stages deliberately ignore reset so a device held selected through
    // reset sees no spurious chip-select fall afterwards.
    always_ff @(posedge i_clock) begin
        r_sck_sync  <= {r_sck_sync[1:0], i_sck};
        r_ss_sync   <= {r_ss_sync[1:0], i_ss};
        r_mosi_sync <= {r_mosi_sync[0], i_mosi};
    end

    assign o_sck_rise  = r_sck_sync[1] & ~r_sck_sync[2];
    assign o_sck_fall  = ~r_sck_sync[1] & r_sck_sync[2];
    assign o_ss_active = ~r_ss_sync[1];
    assign o_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
    assign o_mosi_s    = r_mosi_sync[1];

endmodule

// File: rtl/spi_flash_slave.sv
// SPI NOR flash responder (mode 0): READ 0x03, optional FAST READ 0x0B under
// FLASH_FAST_READ_EN. Backing store loaded via backdoor port; MEM_WORDS >= 64.
module spi_flash_slave
    import spi_flash_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int SS_IDX    = 0,
    parameter int SS_NUM    = 8
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_spi_sck,
    input  logic [SS_NUM-1:0]            i_spi_ss,
    input  logic                         i_spi_mosi,
    output logic                         o_spi_miso,
    input  logic                         i_mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] i_mem_addr,
    input  logic [31:0]                  i_mem_wdata,
    output logic                         o_rd_active,
    output logic                         o_bad_cmd
);

    localparam int         MEM_AW    = $clog2(MEM_WORDS);
    localparam int         BYTE_AW   = MEM_AW + 2;
    localparam logic [4:0] ADDR_LAST = 5'(FLASH_ADDR_BITS - 1);

    logic w_sck_rise, w_sck_fall, w_ss_active, w_ss_fall, w_mosi;
    logic w_unused_ss;

    flash_state_e r_state, w_state_nxt;
    logic [4:0]         r_bit_cnt;
    logic [BYTE_AW-2:0] r_shift;
    logic [BYTE_AW-1:0] r_byte_ptr;
    logic [7:0]         r_data;
    logic               r_miso, r_rd_active, r_bad_cmd;
    logic [31:0]        r_mem [MEM_WORDS];

    logic [BYTE_AW-1:0] w_shift_in, w_fetch_ptr, w_ptr_inc;
    logic [7:0]         w_opcode, w_fetch_byte;
    logic               w_bad_cmd_s, w_load_ptr_s, w_fetch_s, w_next_byte_s;
    logic               w_count_rise_s, w_data_fall_s;
`ifdef FLASH_FAST_READ_EN
    logic               w_set_fast_s, r_fast;
`endif

    assign w_unused_ss = ^i_spi_ss;

    spi_pin_sync u_pin_sync (
        .i_clock     (i_clock),
        .i_sck       (i_spi_sck),
        .i_ss        (i_spi_ss[SS_IDX]),
        .i_mosi      (i_spi_mosi),
        .o_sck_rise  (w_sck_rise),
        .o_sck_fall  (w_sck_fall),
        .o_ss_active (w_ss_active),
        .o_ss_fall   (w_ss_fall),
        .o_mosi_s    (w_mosi)
    );

    assign w_shift_in     = {r_shift, w_mosi};
    assign w_opcode       = w_shift_in[7:0];
    assign w_ptr_inc      = r_byte_ptr + {{(BYTE_AW-1){1'b0}}, 1'b1};
    assign w_count_rise_s = w_sck_rise && ((r_state == ST_CMD) || (r_state == ST_ADDR)
                                           || (r_state == ST_DUMMY));
    assign w_data_fall_s  = w_sck_fall && (r_state == ST_DATA);
    assign w_next_byte_s  = w_data_fall_s && (r_bit_cnt == 5'd7);

    // Fetch address: the freshly shifted address, the next byte, or the held pointer.
    assign w_fetch_ptr  = w_load_ptr_s ? w_shift_in : (w_next_byte_s ? w_ptr_inc : r_byte_ptr);
    assign w_fetch_byte = byte_lane(r_mem[w_fetch_ptr[BYTE_AW-1:2]], w_fetch_ptr[1:0]);

    // FSM state register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes; deselect overrides every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_bad_cmd_s  = 1'b0;
        w_load_ptr_s = 1'b0;
        w_fetch_s    = 1'b0;
`ifdef FLASH_FAST_READ_EN
        w_set_fast_s = 1'b0;
`endif
        if (!w_ss_active) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) w_state_nxt = ST_CMD;
                    else           w_state_nxt = ST_IDLE;
                end
                ST_CMD: begin
                    if (w_sck_rise && (r_bit_cnt == 5'd7)) begin
                        if (w_opcode == FLASH_OP_READ) begin
                            w_state_nxt = ST_ADDR;
`ifdef FLASH_FAST_READ_EN
                        end else if (w_opcode == FLASH_OP_FAST_READ) begin
                            w_state_nxt  = ST_ADDR;
                            w_set_fast_s = 1'b1;
`endif
                        end else begin
                            w_bad_cmd_s = 1'b1;
                            w_state_nxt = ST_IGNORE;
                        end
                    end else begin
                        w_state_nxt = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && (r_bit_cnt == ADDR_LAST)) begin
                        w_load_ptr_s = 1'b1;
`ifdef FLASH_FAST_READ_EN
                        if (r_fast) begin
                            w_state_nxt = ST_DUMMY;
                        end else begin
                            w_state_nxt = ST_DATA;
                            w_fetch_s   = 1'b1;
                        end
`else
                        w_state_nxt = ST_DATA;
                        w_fetch_s   = 1'b1;
`endif
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end
`ifdef FLASH_FAST_READ_EN
                ST_DUMMY: begin
                    if (w_sck_rise && (r_bit_cnt == 5'(FLASH_DUMMY_CYCLES - 1))) begin
                        w_state_nxt = ST_DATA;
                        w_fetch_s   = 1'b1;
                    end else begin
                        w_state_nxt = ST_DUMMY;
                    end
                end
`endif
                ST_DATA:   w_state_nxt = ST_DATA;
                ST_IGNORE: w_state_nxt = ST_IGNORE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Counters, shift registers, byte pointer and registered pin outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bit_cnt   <= 5'd0;
            r_shift     <= '0;
            r_byte_ptr  <= '0;
            r_data      <= 8'hFF;
            r_miso      <= 1'b1;
            r_rd_active <= 1'b0;
            r_bad_cmd   <= 1'b0;
        end else begin
            r_bad_cmd   <= w_bad_cmd_s;
            r_rd_active <= (w_state_nxt == ST_DATA);

            if (w_state_nxt != r_state)  r_bit_cnt <= 5'd0;
            else if (w_next_byte_s)      r_bit_cnt <= 5'd0;
            else if (w_count_rise_s || w_data_fall_s) r_bit_cnt <= r_bit_cnt + 5'd1;

            if (w_sck_rise && ((r_state == ST_CMD) || (r_state == ST_ADDR)))
                r_shift <= w_shift_in[BYTE_AW-2:0];

            if (w_load_ptr_s)       r_byte_ptr <= w_shift_in;
            else if (w_next_byte_s) r_byte_ptr <= w_ptr_inc;

            if (w_fetch_s || w_next_byte_s) r_data <= w_fetch_byte;
            else if (w_data_fall_s)         r_data <= {r_data[6:0], 1'b0};

            if (w_state_nxt != ST_DATA) r_miso <= 1'b1;
            else if (w_data_fall_s)     r_miso <= r_data[7];
        end
    end

`ifdef FLASH_FAST_READ_EN
    // Remembers that the current transaction is a FAST READ.
    always_ff @(posedge i_clock) begin
        if (i_reset)                  r_fast <= 1'b0;
        else if (r_state == ST_IDLE)  r_fast <= 1'b0;
        else if (w_set_fast_s)        r_fast <= 1'b1;
    end
`endif

    // Backdoor store; a same-cycle fetch of this word reads the old contents.
    always_ff @(posedge i_clock) begin
        if (i_mem_we) r_mem[i_mem_addr] <= i_mem_wdata;
    end

    assign o_spi_miso  = r_miso;
    assign o_rd_active = r_rd_active;
    assign o_bad_cmd   = r_bad_cmd;

endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed bench for spi_flash_slave; mode-0 SPI master with 8-clock SCK phases.
module tb_spi_flash_slave;

    localparam int SCK_HALF = 8;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_spi_sck = 1'b0;
    logic [7:0]  i_spi_ss = 8'hFF;
    logic        i_spi_mosi = 1'b0;
    logic        o_spi_miso;
    logic        i_mem_we = 1'b0;
    logic [9:0]  i_mem_addr = 10'd0;
    logic [31:0] i_mem_wdata = 32'd0;
    logic        o_rd_active;
    logic        o_bad_cmd;

    int checks = 0;
    int errors = 0;
    int bad_cnt = 0;
    int bad_snap;
    logic [7:0] rx;

    spi_flash_slave #(.MEM_WORDS(1024), .SS_IDX(0), .SS_NUM(8)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_spi_sck   (i_spi_sck),
        .i_spi_ss    (i_spi_ss),
        .i_spi_mosi  (i_spi_mosi),
        .o_spi_miso  (o_spi_miso),
        .i_mem_we    (i_mem_we),
        .i_mem_addr  (i_mem_addr),
        .i_mem_wdata (i_mem_wdata),
        .o_rd_active (o_rd_active),
        .o_bad_cmd   (o_bad_cmd)
    );

    always #5 i_clock = ~i_clock;

    // Count bad_cmd pulses, sampled away from the active edge.
    always @(negedge i_clock) begin
        if (o_bad_cmd === 1'b1) bad_cnt <= bad_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_write(input logic [9:0] addr, input logic [31:0] data);
        i_mem_we = 1'b1; i_mem_addr = addr; i_mem_wdata = data;
        tick(1);
        i_mem_we = 1'b0;
    endtask

    task automatic ss_set(input logic level);
        i_spi_ss[0] = level;
        tick(6);
    endtask

    // Shift nbits of tx MSB-first; MISO is sampled at the end of each low phase.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx_o);
        rx_o = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            i_spi_mosi = tx[7-i];
            tick(SCK_HALF);
            rx_o = {rx_o[6:0], o_spi_miso};
            i_spi_sck = 1'b1;
            tick(SCK_HALF);
            i_spi_sck = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] dummy_rx;
        spi_xfer(op, 8, dummy_rx);
        spi_xfer(addr[23:16], 8, dummy_rx);
        spi_xfer(addr[15:8], 8, dummy_rx);
        spi_xfer(addr[7:0], 8, dummy_rx);
    endtask

    initial begin
        tick(5);
        i_reset = 1'b0;
        tick(1);
        chk("reset_miso", {31'd0, o_spi_miso}, 32'd1);
        chk("reset_rd_active", {31'd0, o_rd_active}, 32'd0);
        chk("reset_bad_cmd", {31'd0, o_bad_cmd}, 32'd0);

        mem_write(10'd0, 32'h44332211);
        mem_write(10'd1, 32'h88776655);
        mem_write(10'd1023, 32'hDDCCBBAA);

        // SCK/MOSI activity with chip select high is ignored.
        spi_xfer(8'h9F, 8, rx);
        tick(6);
        chk("desel_bad_cmd", bad_cnt, 32'd0);
        chk("desel_rd_active", {31'd0, o_rd_active}, 32'd0);
        chk("desel_miso", {31'd0, o_spi_miso}, 32'd1);

        // Plain read from address 0.
        ss_set(1'b0);
        send_hdr(8'h03, 24'h000000);
        chk("t1_rd_active_start", {31'd0, o_rd_active}, 32'd1);
        spi_xfer(8'h00, 8, rx); chk("t1_byte0", rx, 32'h11);
        spi_xfer(8'h00, 8, rx); chk("t1_byte1", rx, 32'h22);
        spi_xfer(8'h00, 8, rx); chk("t1_byte2", rx, 32'h33);
        spi_xfer(8'h00, 8, rx); chk("t1_byte3", rx, 32'h44);
        chk("t1_rd_active_end", {31'd0, o_rd_active}, 32'd1);
        ss_set(1'b1);
        chk("t1_rd_active_idle", {31'd0, o_rd_active}, 32'd0);
        chk("t1_miso_idle", {31'd0, o_spi_miso}, 32'd1);

        // Read across the top of the store wraps to byte 0.
        ss_set(1'b0);
        send_hdr(8'h03, 24'h000FFE);
        spi_xfer(8'h00, 8, rx); chk("t2_byte0", rx, 32'hCC);
        spi_xfer(8'h00, 8, rx); chk("t2_byte1", rx, 32'hDD);
        spi_xfer(8'h00, 8, rx); chk("t2_byte2", rx, 32'h11);
        spi_xfer(8'h00, 8, rx); chk("t2_byte3", rx, 32'h22);
        ss_set(1'b1);

        // Unsupported opcode.
        bad_snap = bad_cnt;
        ss_set(1'b0);
        spi_xfer(8'h9F, 8, rx);
        tick(6);
        chk("t3_bad_pulse", bad_cnt - bad_snap, 32'd1);
        for (int b = 0; b < 4; b++) begin
            spi_xfer(8'h00, 8, rx);
            chk("t3_miso_high", rx, 32'hFF);
        end
        chk("t3_rd_active", {31'd0, o_rd_active}, 32'd0);
        chk("t3_single_pulse", bad_cnt - bad_snap, 32'd1);
        ss_set(1'b1);

        // Abort after 4 data bits, then a fresh read at byte 4.
        ss_set(1'b0);
        send_hdr(8'h03, 24'h000000);
        spi_xfer(8'h00, 4, rx); chk("t4_partial_nibble", rx, 32'h01);
        ss_set(1'b1);
        ss_set(1'b0);
        send_hdr(8'h03, 24'h000004);
        spi_xfer(8'h00, 8, rx); chk("t4_byte0", rx, 32'h55);
        spi_xfer(8'h00, 8, rx); chk("t4_byte1", rx, 32'h66);
        ss_set(1'b1);

        // Reset in the middle of the address phase while still selected.
        ss_set(1'b0);
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h00, 8, rx);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx);
        spi_xfer(8'h00, 8, rx); chk("t5_no_data0", rx, 32'hFF);
        spi_xfer(8'h00, 8, rx); chk("t5_no_data1", rx, 32'hFF);
        chk("t5_rd_active", {31'd0, o_rd_active}, 32'd0);
        ss_set(1'b1);
        ss_set(1'b0);
        send_hdr(8'h03, 24'h000001);
        spi_xfer(8'h00, 8, rx); chk("t5_recover_byte", rx, 32'h22);
        ss_set(1'b1);

        // FAST READ at byte 1.
        bad_snap = bad_cnt;
        ss_set(1'b0);
        send_hdr(8'h0B, 24'h000001);
`ifdef FLASH_FAST_READ_EN
        spi_xfer(8'h00, 8, rx); chk("t6_dummy_miso", rx, 32'hFF);
        spi_xfer(8'h00, 8, rx); chk("t6_byte0", rx, 32'h22);
        spi_xfer(8'h00, 8, rx); chk("t6_byte1", rx, 32'h33);
        chk("t6_no_bad_cmd", bad_cnt - bad_snap, 32'd0);
`else
        spi_xfer(8'h00, 8, rx); chk("t6_miso_high0", rx, 32'hFF);
        spi_xfer(8'h00, 8, rx); chk("t6_miso_high1", rx, 32'hFF);
        chk("t6_bad_pulse", bad_cnt - bad_snap, 32'd1);
        chk("t6_rd_active", {31'd0, o_rd_active}, 32'd0);
`endif
        ss_set(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
